// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory-port arbiter:
//   - arb_state_e          : FSM state encoding (IDLE / FETCH / DATA)
//   - DEFAULT_WIDTH        : default address/data width of every bus
//   - DEFAULT_STARVE_LIMIT : default number of consecutive data grants that
//                            fetch may lose before it is forced to win
//   - cnt_bits()           : counter width able to hold 0..limit
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DEFAULT_WIDTH        = 32;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    function automatic int cnt_bits(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of data grants made while fetch was waiting.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a data grant was made while fetch was requesting
//   clr       : a fetch grant was made (clear has priority over inc)
//   at_limit  : count has reached LIMIT; fetch must win the next arbitration
// -----------------------------------------------------------------------------
module arb_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CW    = cnt_bits(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CW-1:0] cnt;

    assign at_limit = (cnt >= CW'(LIMIT));

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between instruction fetch (read-only) and the
// load/store unit (read/write). One memory access is outstanding at a time;
// data normally wins, but after STARVE_LIMIT consecutive data grants taken
// while fetch waited, fetch is forced to win.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr/if_flush        : fetch request, address, jump (squash)
//   if_data/if_valid/if_delay      : fetch result, 1-cycle valid, stall
//   d_req/d_we/d_addr/d_wdata      : load/store request
//   d_rdata/d_valid/d_delay        : load result, 1-cycle completion, stall
//   m_addr/m_wdata/m_read/m_write  : registered memory request, held until
//                                    m_ready
//   m_rdata/m_ready                : memory response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int width        = DEFAULT_WIDTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    // fetch side
    input  logic             if_req,
    input  logic [width-1:0] if_addr,
    input  logic             if_flush,
    output logic [width-1:0] if_data,
    output logic             if_valid,
    output logic             if_delay,
    // data side
    input  logic             d_req,
    input  logic             d_we,
    input  logic [width-1:0] d_addr,
    input  logic [width-1:0] d_wdata,
    output logic [width-1:0] d_rdata,
    output logic             d_valid,
    output logic             d_delay,
    // memory side
    output logic [width-1:0] m_addr,
    output logic [width-1:0] m_wdata,
    output logic             m_read,
    output logic             m_write,
    input  logic [width-1:0] m_rdata,
    input  logic             m_ready
);

    arb_state_e state, state_nxt;
    logic       grant_d, grant_f, done;
    logic       squash;
    logic       at_limit;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (grant_d & if_req),
        .clr      (grant_f),
        .at_limit (at_limit)
    );

    // Stalls fall in the same cycle the requester's result is presented.
    assign if_delay = if_req & ~if_valid;
    assign d_delay  = d_req  & ~d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req && (!if_req || !at_limit)) begin
                    grant_d   = 1'b1;
                    state_nxt = DATA;
                end else if (if_req) begin
                    grant_f   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH, DATA: begin
                if (m_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_addr   <= '0;
            m_wdata  <= '0;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            if_data  <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            squash   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_d) begin
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_write <= d_we;
                m_read  <= ~d_we;
            end else if (grant_f) begin
                m_addr <= if_addr;
                m_read <= 1'b1;
            end

            if (done) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
                if (state == FETCH) begin
                    if_data  <= m_rdata;
                    // A jump arriving on the completing edge also drops the result.
                    if_valid <= ~(squash | if_flush);
                end else begin
                    // m_write still holds the latched direction of this access.
                    if (!m_write) begin
                        d_rdata <= m_rdata;
                    end
                    d_valid <= 1'b1;
                end
            end

            if (done) begin
                squash <= 1'b0;
            end else if (state == FETCH && if_flush) begin
                squash <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized fetch/load/store traffic against
// a transaction-level reference model with its own copy of memory.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         if_req = 1'b0, if_flush = 1'b0;
    logic [W-1:0] if_addr = '0;
    logic [W-1:0] if_data;
    logic         if_valid, if_delay;
    logic         d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0] d_addr = '0, d_wdata = '0;
    logic [W-1:0] d_rdata;
    logic         d_valid, d_delay;
    logic [W-1:0] m_addr, m_wdata;
    logic         m_read, m_write;
    logic [W-1:0] m_rdata = '0;
    logic         m_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.width(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_data  (if_data),
        .if_valid (if_valid),
        .if_delay (if_delay),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_delay  (d_delay),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory device ----------------
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    int          fixed_wait = 0;   // <0: random wait 0..3 per access
    bit          mem_busy   = 1'b0;
    int          wait_left  = 0;

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    // Inputs as sampled by the DUT at the edge a tick crosses.
    logic        pre_if_req, pre_flush, pre_d_req, pre_d_we, pre_m_ready;
    logic [31:0] pre_if_addr, pre_d_addr, pre_d_wdata;

    task automatic tick();
        pre_if_req  = if_req;
        pre_if_addr = if_addr;
        pre_flush   = if_flush;
        pre_d_req   = d_req;
        pre_d_we    = d_we;
        pre_d_addr  = d_addr;
        pre_d_wdata = d_wdata;
        pre_m_ready = m_ready;
        if (m_write && m_ready && !rst) mem[idx(m_addr)] = m_wdata;
        @(posedge clk);
        #1;
        if (m_read || m_write) begin
            if (!mem_busy) begin
                mem_busy  = 1'b1;
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
                m_ready = 1'b1;
                m_rdata = m_read ? mem[idx(m_addr)] : $urandom;
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
                wait_left--;
            end
        end else begin
            mem_busy = 1'b0;
            m_ready  = 1'b0;
            m_rdata  = $urandom;
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          owner = 0;        // 0 none, 1 fetch, 2 data
    logic        o_we;
    logic [31:0] o_addr, o_wdata;
    int          mcnt = 0;         // data grants taken while fetch waited
    bit          msq  = 1'b0;      // outstanding fetch has been jumped away from
    bit          exp_if_valid, exp_d_valid;
    logic [31:0] exp_if_data, exp_d_rdata;

    task automatic model_step_and_check();
        exp_if_valid = 1'b0;
        exp_d_valid  = 1'b0;
        if (owner == 0) begin
            if (pre_d_req && (!pre_if_req || mcnt < LIMIT)) begin
                owner   = 2;
                o_we    = pre_d_we;
                o_addr  = pre_d_addr;
                o_wdata = pre_d_wdata;
                if (pre_if_req && mcnt < LIMIT) mcnt++;
            end else if (pre_if_req) begin
                owner  = 1;
                o_addr = pre_if_addr;
                mcnt   = 0;
                msq    = 1'b0;
            end
        end else begin
            if (owner == 1 && pre_flush) msq = 1'b1;
            if (pre_m_ready) begin
                if (owner == 1) begin
                    exp_if_valid = !msq;
                    exp_if_data  = ref_mem[idx(o_addr)];
                end else begin
                    exp_d_valid = 1'b1;
                    if (o_we) ref_mem[idx(o_addr)] = o_wdata;
                    else      exp_d_rdata = ref_mem[idx(o_addr)];
                end
                owner = 0;
            end
        end
        check("rnd_m_read",  m_read,  (owner == 1) || (owner == 2 && !o_we));
        check("rnd_m_write", m_write, (owner == 2) && o_we);
        if (owner != 0)           check("rnd_m_addr",  m_addr,  o_addr);
        if (owner == 2 && o_we)   check("rnd_m_wdata", m_wdata, o_wdata);
        check("rnd_if_valid", if_valid, exp_if_valid);
        check("rnd_d_valid",  d_valid,  exp_d_valid);
        if (exp_if_valid) check("rnd_if_data", if_data, exp_if_data);
        if (exp_d_valid)  check("rnd_d_rdata", d_rdata, exp_d_rdata);
        check("rnd_if_delay", if_delay, if_req & ~exp_if_valid);
        check("rnd_d_delay",  d_delay,  d_req & ~exp_d_valid);
    endtask

    // Requesters hold a request until its valid pulse, then may present the
    // next one in that same cycle.
    bit if_pend = 1'b0, d_pend = 1'b0;

    task automatic drive_requesters();
        if (exp_if_valid) if_pend = 1'b0;
        if (exp_d_valid)  d_pend  = 1'b0;
        if_flush = 1'b0;
        if (if_pend && ($urandom % 16) == 0) begin
            if_flush = 1'b1;
            if_addr  = {26'd0, 4'($urandom), 2'b00};
        end
        if (!if_pend && ($urandom % 3) == 0) begin
            if_pend = 1'b1;
            if_addr = {26'd0, 4'($urandom), 2'b00};
        end
        if (!d_pend && ($urandom % 4) != 0) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom);
            d_addr  = {26'd0, 4'($urandom), 2'b00};
            d_wdata = $urandom;
        end
        if_req = if_pend;
        d_req  = d_pend;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          got;
        bit          first_f;
        int          ngr;
        logic [9:0]  gbits;
        bit          prev_strobe;

        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[1] = 32'h0000_0099;

        // ---- reset state ----
        rst = 1'b1;
        tick();
        tick();
        check("rst_m_read",   m_read,   1'b0);
        check("rst_m_write",  m_write,  1'b0);
        check("rst_m_addr",   m_addr,   32'h0);
        check("rst_m_wdata",  m_wdata,  32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_d_valid",  d_valid,  1'b0);
        check("rst_if_data",  if_data,  32'h0);
        check("rst_d_rdata",  d_rdata,  32'h0);
        check("rst_state",    32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // ---- fetch only, one wait cycle ----
        fixed_wait = 1;
        if_req  = 1'b1;
        if_addr = 32'h4;
        tick();
        check("f1_m_read",   m_read,   1'b1);
        check("f1_m_addr",   m_addr,   32'h4);
        check("f1_if_delay", if_delay, 1'b1);
        tick();
        check("f1_m_read_held", m_read, 1'b1);
        check("f1_m_addr_held", m_addr, 32'h4);
        tick();
        check("f1_if_valid", if_valid, 1'b1);
        check("f1_if_data",  if_data,  32'h99);
        check("f1_if_delay_low", if_delay, 1'b0);
        check("f1_m_read_drop",  m_read,   1'b0);
        if_req = 1'b0;
        tick();
        check("f1_if_valid_pulse", if_valid, 1'b0);

        // ---- conflict: data wins, then fetch ----
        fixed_wait = 0;
        if_req  = 1'b1;
        if_addr = 32'h8;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        tick();
        check("c_m_addr_data", m_addr,   32'h100);
        check("c_m_read",      m_read,   1'b1);
        check("c_if_delay1",   if_delay, 1'b1);
        check("c_d_delay1",    d_delay,  1'b1);
        tick();
        check("c_d_valid",   d_valid,  1'b1);
        check("c_d_rdata",   d_rdata,  32'h1000_0000);
        check("c_if_delay2", if_delay, 1'b1);
        d_req = 1'b0;
        tick();
        check("c_m_addr_fetch", m_addr,  32'h8);
        check("c_d_valid_pulse", d_valid, 1'b0);
        check("c_if_delay3",    if_delay, 1'b1);
        tick();
        check("c_if_valid",  if_valid, 1'b1);
        check("c_if_data",   if_data,  32'h1000_0002);
        check("c_if_delay4", if_delay, 1'b0);
        if_req = 1'b0;
        tick();

        // ---- starvation: continuous data with fetch waiting ----
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h10;
        if_req  = 1'b1;
        if_addr = 32'hC;
        ngr = 0;
        gbits = '0;
        prev_strobe = 1'b0;
        first_f = 1'b1;
        for (int c = 0; c < 80 && ngr < 10; c++) begin
            tick();
            if ((m_read || m_write) && !prev_strobe) begin
                gbits = {gbits[8:0], (m_addr == 32'hC)};
                ngr++;
                if (m_addr == 32'hC && first_f) begin
                    first_f = 1'b0;
                    check("s_cnt_cleared", 32'(dut.u_starve.cnt), 32'd0);
                end
            end
            prev_strobe = m_read | m_write;
        end
        check("s_grant_count", ngr, 10);
        check("s_grant_seq", 32'(gbits), 32'b0000100001);
        d_req  = 1'b0;
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // ---- store with three wait cycles ----
        fixed_wait = 3;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            else       tick();
            check("st_m_write", m_write, 1'b1);
            check("st_m_read",  m_read,  1'b0);
            check("st_m_addr",  m_addr,  32'h20);
            check("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
            check("st_d_valid_wait", d_valid, 1'b0);
        end
        tick();
        check("st_d_valid",  d_valid, 1'b1);
        check("st_m_write_drop", m_write, 1'b0);
        check("st_d_rdata_kept", d_rdata, 32'h1000_0004);
        check("st_mem", mem[8], 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        check("st_d_valid_pulse", d_valid, 1'b0);

        // ---- flush while fetch waits ----
        fixed_wait = 2;
        if_req  = 1'b1;
        if_addr = 32'h30;
        tick();
        check("fl_m_addr", m_addr, 32'h30);
        if_flush = 1'b1;
        if_addr  = 32'h34;
        tick();
        if_flush = 1'b0;
        check("fl_m_addr_held", m_addr, 32'h30);
        tick();
        check("fl_m_read_held", m_read, 1'b1);
        tick();
        check("fl_no_valid", if_valid, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (if_valid) got = 1'b1;
        end
        check("fl_refetch_valid", got, 1'b1);
        check("fl_refetch_data", if_data, 32'h1000_000D);

        // ---- flush coincident with m_ready ----
        fixed_wait = 0;
        if_addr = 32'h38;
        tick();
        check("flr_m_ready", m_ready, 1'b1);
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        check("flr_no_valid", if_valid, 1'b0);
        tick();
        tick();
        check("flr_valid", if_valid, 1'b1);
        check("flr_data",  if_data,  32'h1000_000E);
        if_req = 1'b0;
        tick();

        // ---- reset in the middle of a pending write ----
        fixed_wait = 10;
        if_req  = 1'b1;
        if_addr = 32'h4;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h24;
        d_wdata = 32'hCAFE_F00D;
        tick();
        check("rs_m_write", m_write, 1'b1);
        check("rs_cnt_one", 32'(dut.u_starve.cnt), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rs_m_write_drop", m_write, 1'b0);
        check("rs_m_read",       m_read,  1'b0);
        check("rs_d_valid",      d_valid, 1'b0);
        check("rs_state",        32'(dut.state), 32'(IDLE));
        check("rs_cnt_zero",     32'(dut.u_starve.cnt), 32'd0);
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (d_valid || m_write || m_read) got = 1'b1;
        end
        check("rs_quiet_after", got, 1'b0);
        check("rs_mem_untouched", mem[9], 32'h1000_0009);

        // ---- randomized traffic against the reference model ----
        fixed_wait = -1;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        owner = 0;
        mcnt = 0;
        msq = 1'b0;
        exp_d_rdata = 32'h0;
        exp_if_valid = 1'b0;
        exp_d_valid = 1'b0;
        if_pend = 1'b0;
        d_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            model_step_and_check();
            drive_requesters();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch (read-only) and the load/store unit (read/write).
- Sits between the fetch stage and the data-memory stage on one side, and the unified memory on the other.
- Drives the fetch stage's delay (stall) input and consumes its jump as a flush that squashes an in-flight fetch.
- Data accesses normally win arbitration; a starvation counter guarantees fetch progress.

Parameters:
width, 32, address/data width of every bus
STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits before fetch is forced to win

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch requests instruction at if_addr
if_addr  in  width  fetch address
if_flush  in  1  jump taken; discard any in-flight fetch result
if_data  out  width  returned instruction
if_valid  out  1  one-cycle pulse: if_data valid
if_delay  out  1  stall to fetch: if_req & ~if_valid
d_req  in  1  load/store request
d_we  in  1  1 = store, 0 = load
d_addr  in  width  data address
d_wdata  in  width  store data
d_rdata  out  width  load data
d_valid  out  1  one-cycle pulse: data access complete (load or store)
d_delay  out  1  stall to data stage: d_req & ~d_valid
m_addr  out  width  memory address
m_wdata  out  width  memory write data
m_read  out  1  memory read strobe, held until m_ready
m_write  out  1  memory write strobe, held until m_ready
m_rdata  in  width  memory read data, valid with m_ready
m_ready  in  1  memory completes current access this cycle

Behaviour:
- States: IDLE, FETCH, DATA. One access outstanding at most; no aborts of memory transactions except via rst.
- Reset: state IDLE; all outputs 0 (if_data, d_rdata, m_addr, m_wdata cleared); starve_cnt 0; squash 0.
- IDLE arbitration, evaluated each cycle:
  - d_req & (~if_req | starve_cnt < STARVE_LIMIT) -> DATA.
  - Otherwise if_req -> FETCH.
  - Otherwise stay in IDLE.
- Grant edge: latch m_addr from the winner; for DATA also latch m_wdata = d_wdata and drive m_write = d_we, m_read = ~d_we. FETCH drives m_read = 1.
- Strobes and m_addr/m_wdata are registered and held stable until m_ready is sampled high.
- Completion: on the edge where m_ready = 1:
  - Drop strobes and return to IDLE.
  - FETCH: if_data <= m_rdata; if_valid <= ~(squash | if_flush).
  - DATA: d_rdata <= m_rdata for loads (unchanged for stores); d_valid <= 1.
- if_valid and d_valid are single-cycle pulses.
- Latency: request sampled in IDLE at cycle N, strobe visible N+1; m_ready at N+1 gives valid at N+2. Minimum 2 cycles per access; back-to-back grants require an IDLE cycle.
- Requester inputs are sampled only at the grant edge; requesters hold request/address until their valid pulse.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each DATA grant made while if_req = 1.
  - It clears on every FETCH grant.
- Flush:
  - if_flush in FETCH sets squash; the memory read still completes and its result is dropped (no if_valid).
  - Flush coincident with m_ready also squashes.
  - squash clears on return to IDLE.
  - Flush in IDLE or DATA has no effect.
- Simultaneous if_req & d_req with starve_cnt < STARVE_LIMIT: data wins; if_delay stays high.
- Reset mid-access: state returns to IDLE next edge; strobes drop; no valid pulse. Memory tolerates an abandoned access.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2);
  - the default width;
  - the STARVE_LIMIT default.
- One natural sub-module: arb_starve_counter (saturating counter with inc/clear/limit-reached output).
- FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Fetch only: if_req = 1, if_addr = 32'h4, m_ready one cycle after m_read with m_rdata = 32'h99 -> m_addr = 4, m_read held; if_data = 32'h99 with if_valid pulse; if_delay low that cycle.
- Conflict: if_req & d_req (load, 32'h100) together, m_ready immediate -> data granted first, d_valid at cycle 2; fetch granted next; if_delay high until its if_valid.
- Starvation: d_req held continuously with if_req = 1, STARVE_LIMIT = 4 -> exactly 4 data grants, then a fetch grant, then starve_cnt = 0.
- Store: d_we = 1, d_addr = 32'h20, d_wdata = 32'hDEADBEEF, m_ready after 3 wait cycles -> m_write held 4 cycles with stable addr/data; d_valid pulse; d_rdata unchanged.
- Flush: if_flush pulses while FETCH waits on m_ready -> read completes, no if_valid; the next fetch for the new address returns normally.
- Reset mid-DATA: rst during a pending write -> next edge m_write = 0, state IDLE, no d_valid; starve_cnt 0.
